fifo_rd_serializer: RTL and testbench
=====================================

Name: fifo_rd_serializer

Overview:
Dequeue-side stage that sits directly downstream of the distributed-RAM FIFO. It pops wide words from the FIFO read port, where read data is combinational and valid whenever the FIFO is not empty. It then emits each word as RATIO narrow beats on a valid/ready stream. Prefetch on the last beat keeps back-to-back words bubble-free.

Parameters:
OUT_W, 8, output beat width in bits
RATIO, 4, beats per FIFO word; legal range is RATIO >= 2; FIFO word width = OUT_W*RATIO
MSB_FIRST, 0, 0 = least-significant slice emitted first; 1 = most-significant slice first

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
i_en  input  1  enable; mirrors the FIFO enable and gates pops only
i_fifo_empty  input  1  FIFO empty flag
i_fifo_rddata  input  OUT_W*RATIO  FIFO read data; valid in the same cycle while i_fifo_empty=0
o_fifo_rden  output  1  FIFO read enable (pop strobe)
o_tdata  output  OUT_W  output beat data, registered
o_tvalid  output  1  output beat valid, registered
i_tready  input  1  downstream ready
o_busy  output  1  high while a word is held, i.e. equal to o_tvalid

Behaviour:
- Reset: rstn is synchronous and active-low; clock is clk. While rstn=0 at a clk edge:
  - o_tvalid=0, o_tdata=0, beat counter=0, holding register=0, state=IDLE.
  - o_fifo_rden is forced 0 combinationally while rstn=0.
- Internal state:
  - Holding register, OUT_W*RATIO bits.
  - Beat counter, $clog2(RATIO) bits.
  - 2-state FSM: IDLE (no word held) and SERIAL (word held, o_tvalid=1).
- Beat transfer: a beat transfers on a clk edge where o_tvalid=1 and i_tready=1.
- Beat slice selection: beat k (k = counter value) is
  - i_fifo_rddata[k*OUT_W +: OUT_W] as captured, when MSB_FIRST=0;
  - slice (RATIO-1-k), when MSB_FIRST=1.
- Pop rule: o_fifo_rden = rstn & i_en & !i_fifo_empty & (state==IDLE | last_xfer).
  - last_xfer = o_tvalid & i_tready & (counter == RATIO-1).
  - o_fifo_rden is combinational from i_tready.
- IDLE:
  - If a pop occurs: capture i_fifo_rddata, set counter=0, drive o_tdata with beat 0, o_tvalid=1, go to SERIAL.
  - Latency from FIFO not-empty to o_tvalid is 1 cycle.
- SERIAL, non-last beat transfer: counter+1; o_tdata updates to the next slice on the same edge.
- SERIAL, last beat transfer:
  - With a pop: load the new word, counter=0, stay in SERIAL. o_tvalid stays 1 with no bubble.
  - Without a pop (FIFO empty or i_en=0): o_tvalid=0, go to IDLE.
- Stalls: o_tvalid/o_tdata stay stable while i_tready=0. Once asserted, o_tvalid never drops without a transfer.
- i_en=0: no pops. A word already held continues to drain normally, because the downstream handshake is independent of i_en.
- Empty boundary: if i_fifo_empty=1, the block never pops and i_fifo_rddata is ignored.
- Reset mid-word: the held word and any remaining beats are discarded. Data already popped from the FIFO is lost; this is by design.
- Throughput: 1 beat/cycle sustained while the FIFO is non-empty and i_tready=1. The FIFO is popped once per RATIO beats.

Optional Feature:
Macro FIFO_RD_SER_LAST_EN.
- Defined:
  - Adds output port o_tlast (1 bit, registered).
  - o_tlast=1 exactly when o_tvalid=1 and counter==RATIO-1; it is stable during stalls.
  - Reset value 0.
- Undefined: port o_tlast does not exist. No word-boundary marking.

Test Plan:
- Reset/idle: rstn=0 for 2 cycles with the FIFO holding data -> o_tvalid=0, o_tdata=0, o_fifo_rden=0. After release with the FIFO non-empty, o_fifo_rden=1 in the first cycle and o_tvalid=1 one cycle later.
- Single word, LSB first: FIFO word 0xDDCCBBAA, i_tready=1 -> beats AA, BB, CC, DD on 4 consecutive cycles. One pop, then o_tvalid=0.
- MSB_FIRST=1 with the same word -> beats DD, CC, BB, AA.
- Back-to-back: words 0x03020100 and 0x07060504 queued, i_tready=1 -> 8 contiguous beats 00..07 with no gap. The second pop coincides with the transfer of beat 03.
- Backpressure: i_tready toggles 1,0,0,1,... -> o_tdata/o_tvalid held during low cycles, no beat lost or duplicated. With FIFO_RD_SER_LAST_EN defined, o_tlast=1 only on beats 03 and 07.
- i_en=0 mid-word after beat 1 of 0x44332211 with a second word queued -> beats 33, 44 still drain, o_fifo_rden stays 0, o_tvalid=0 after 44. Raising i_en resumes with a pop of the queued word.

Source files
------------

// File: rtl/fifo_rd_serializer.sv
// Pops wide words from a show-ahead FIFO and emits them as RATIO narrow valid/ready beats.
// Optional macro FIFO_RD_SER_LAST_EN adds a registered o_tlast marking the final beat of each word.
module fifo_rd_serializer #(
    parameter int OUT_W     = 8,
    parameter int RATIO     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_en,
    input  logic                   i_fifo_empty,
    input  logic [OUT_W*RATIO-1:0] i_fifo_rddata,
    output logic                   o_fifo_rden,
    output logic [OUT_W-1:0]       o_tdata,
    output logic                   o_tvalid,
`ifdef FIFO_RD_SER_LAST_EN
    output logic                   o_tlast,
`endif
    input  logic                   i_tready,
    output logic                   o_busy
);

    localparam int WORD_W = OUT_W * RATIO;
    localparam int CNT_W  = $clog2(RATIO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    typedef enum logic {IDLE, SERIAL} state_t;

    state_t             state, state_n;
    logic [WORD_W-1:0]  hold, hold_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [OUT_W-1:0]   tdata_n;
    logic               tvalid_n;
    logic               tlast_q, tlast_n;
    logic               xfer, last_xfer, pop;

    function automatic logic [OUT_W-1:0] beat_of(input logic [WORD_W-1:0] w, input int k);
        int idx;
        idx = (MSB_FIRST != 0) ? (RATIO - 1 - k) : k;
        return w[idx*OUT_W +: OUT_W];
    endfunction

    assign xfer        = o_tvalid & i_tready;
    assign last_xfer   = xfer & (cnt == CNT_LAST);
    // Pop in the same cycle as the last beat leaves, so consecutive words stream without a bubble.
    assign pop         = rstn & i_en & ~i_fifo_empty & ((state == IDLE) | last_xfer);
    assign o_fifo_rden = pop;
    assign o_busy      = o_tvalid;

    always_comb begin
        state_n  = state;
        hold_n   = hold;
        cnt_n    = cnt;
        tdata_n  = o_tdata;
        tvalid_n = o_tvalid;
        case (state)
            IDLE: begin
                if (pop) begin
                    hold_n   = i_fifo_rddata;
                    cnt_n    = '0;
                    tdata_n  = beat_of(i_fifo_rddata, 0);
                    tvalid_n = 1'b1;
                    state_n  = SERIAL;
                end
            end
            SERIAL: begin
                if (xfer) begin
                    if (cnt != CNT_LAST) begin
                        cnt_n   = cnt + CNT_W'(1);
                        tdata_n = beat_of(hold, int'(cnt) + 1);
                    end else if (pop) begin
                        hold_n  = i_fifo_rddata;
                        cnt_n   = '0;
                        tdata_n = beat_of(i_fifo_rddata, 0);
                    end else begin
                        tvalid_n = 1'b0;
                        state_n  = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        tlast_n = tvalid_n & (cnt_n == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            hold     <= '0;
            cnt      <= '0;
            o_tdata  <= '0;
            o_tvalid <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state    <= state_n;
            hold     <= hold_n;
            cnt      <= cnt_n;
            o_tdata  <= tdata_n;
            o_tvalid <= tvalid_n;
            tlast_q  <= tlast_n;
        end
    end

`ifdef FIFO_RD_SER_LAST_EN
    assign o_tlast = tlast_q;
`else
    logic unused_tlast;
    assign unused_tlast = tlast_q;
`endif

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Scoreboard bench: LSB-first and MSB-first instances share one FIFO model and one downstream ready.
module tb_fifo_rd_serializer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_en;
    logic        i_tready;
    logic        i_fifo_empty;
    logic [31:0] i_fifo_rddata;
    logic        rden, rden_m;
    logic [7:0]  tdata, tdata_m;
    logic        tvalid, tvalid_m, busy, busy_m;
`ifdef FIFO_RD_SER_LAST_EN
    logic        tlast, tlast_m;
`endif

    logic [31:0] mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [8:0]  exp_l[$];
    logic [8:0]  exp_m[$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    fifo_rd_serializer #(.OUT_W(8), .RATIO(4), .MSB_FIRST(0)) dut (
        .clk(clk), .rstn(rstn), .i_en(i_en), .i_fifo_empty(i_fifo_empty),
        .i_fifo_rddata(i_fifo_rddata), .o_fifo_rden(rden), .o_tdata(tdata),
        .o_tvalid(tvalid),
`ifdef FIFO_RD_SER_LAST_EN
        .o_tlast(tlast),
`endif
        .i_tready(i_tready), .o_busy(busy));

    fifo_rd_serializer #(.OUT_W(8), .RATIO(4), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rstn(rstn), .i_en(i_en), .i_fifo_empty(i_fifo_empty),
        .i_fifo_rddata(i_fifo_rddata), .o_fifo_rden(rden_m), .o_tdata(tdata_m),
        .o_tvalid(tvalid_m),
`ifdef FIFO_RD_SER_LAST_EN
        .o_tlast(tlast_m),
`endif
        .i_tready(i_tready), .o_busy(busy_m));

    // Show-ahead FIFO model; garbage on the data bus while empty must never be consumed.
    assign i_fifo_empty  = (rd_ptr == wr_ptr);
    assign i_fifo_rddata = i_fifo_empty ? 32'hDEAD_BEEF : mem[rd_ptr[5:0]];

    always @(posedge clk) if (rden) rd_ptr <= rd_ptr + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr++;
        for (int k = 0; k < 4; k++) begin
            exp_l.push_back({k == 3, w[k*8 +: 8]});
            exp_m.push_back({k == 3, w[(3-k)*8 +: 8]});
        end
    endtask

    task automatic wait_tvalid(input string name);
        int n;
        n = 0;
        while (!tvalid && n < 20) begin
            step();
            n++;
        end
        check(name, {31'd0, tvalid}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((tvalid || exp_l.size() != 0 || exp_m.size() != 0) && n < 80) begin
            step();
            n++;
        end
        check(name, {31'd0, tvalid}, 32'd0);
        check({name, "_drained"}, exp_l.size() + exp_m.size(), 32'd0);
    endtask

    // Monitor: pops the expected beat on every handshake and checks stall stability.
    initial begin : monitor
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (prev_stall) begin
                    check("stall_tvalid", {31'd0, tvalid}, 32'd1);
                    check("stall_tdata", {24'd0, tdata}, {24'd0, prev_data});
                end
                if (tvalid && i_tready) begin
                    if (exp_l.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL lsb_unexpected_beat: got %h, required no beat", tdata);
                    end else begin
                        e = exp_l.pop_front();
                        check("lsb_beat", {24'd0, tdata}, {24'd0, e[7:0]});
`ifdef FIFO_RD_SER_LAST_EN
                        check("lsb_tlast", {31'd0, tlast}, {31'd0, e[8]});
`endif
                    end
                end
                if (tvalid_m && i_tready) begin
                    if (exp_m.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL msb_unexpected_beat: got %h, required no beat", tdata_m);
                    end else begin
                        e = exp_m.pop_front();
                        check("msb_beat", {24'd0, tdata_m}, {24'd0, e[7:0]});
`ifdef FIFO_RD_SER_LAST_EN
                        check("msb_tlast", {31'd0, tlast_m}, {31'd0, e[8]});
`endif
                    end
                end
                prev_stall = tvalid && !i_tready;
                prev_data  = tdata;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin : stimulus
        logic [3:0] pat;
        rstn     = 1'b0;
        i_en     = 1'b1;
        i_tready = 1'b1;
        step();
        push(32'hDDCC_BBAA);
        step();
        check("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("rst_tdata", {24'd0, tdata}, 32'd0);
        check("rst_rden", {31'd0, rden}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        #1;
        check("first_pop", {31'd0, rden}, 32'd1);
        check("first_tvalid_low", {31'd0, tvalid}, 32'd0);
        step();
        check("first_tvalid", {31'd0, tvalid}, 32'd1);
        check("first_beat", {24'd0, tdata}, 32'h0000_00AA);
        check("first_beat_msb", {24'd0, tdata_m}, 32'h0000_00DD);
        wait_idle("single_word");
        check("single_pop_count", rd_ptr, 32'd1);

        // Two queued words must stream as 8 contiguous beats.
        push(32'h0302_0100);
        push(32'h0706_0504);
        wait_tvalid("b2b_start");
        for (int i = 0; i < 8; i++) begin
            check("b2b_no_gap", {31'd0, tvalid}, 32'd1);
            if (i == 3) check("b2b_pop_on_beat3", {31'd0, rden}, 32'd1);
            step();
        end
        wait_idle("b2b");
        check("b2b_pop_count", rd_ptr, 32'd3);

        // Backpressure with ready pattern 1,0,0,1.
        pat = 4'b1001;
        push(32'h1312_1110);
        push(32'h1716_1514);
        for (int i = 0; i < 40; i++) begin
            i_tready = pat[3 - (i % 4)];
            step();
        end
        i_tready = 1'b1;
        wait_idle("backpressure");

        // Drop enable after beat 1 of a word with a second word queued.
        push(32'h4433_2211);
        push(32'h8877_6655);
        wait_tvalid("en_start");
        step();
        step();
        check("en_beat2", {24'd0, tdata}, 32'h0000_0033);
        i_en = 1'b0;
        #1;
        check("en_off_rden_33", {31'd0, rden}, 32'd0);
        step();
        check("en_off_beat44", {24'd0, tdata}, 32'h0000_0044);
        check("en_off_rden_44", {31'd0, rden}, 32'd0);
        step();
        check("en_off_tvalid", {31'd0, tvalid}, 32'd0);
        check("en_off_rden_idle", {31'd0, rden}, 32'd0);
        i_en = 1'b1;
        #1;
        check("en_on_pop", {31'd0, rden}, 32'd1);
        wait_idle("en_resume");
        check("final_pop_count", rd_ptr, 32'd7);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
